// File: rtl/ifetch_unit_if.sv
// Fetch-side bus: Icache request/return channel, decode handshake and back-end redirect.
interface ifetch_unit_if;
  logic         ic_req;
  logic         ic_reqack;
  logic [57:0]  ic_line_addr;
  logic [3:0]   ic_set_index;
  logic [511:0] ic_data;
  logic         ic_task_comp;
  logic         inst_valid;
  logic         inst_ready;
  logic [31:0]  inst;
  logic [63:0]  inst_pc;
  logic         redirect;
  logic [63:0]  redirect_pc;

  modport master (
    output ic_req, ic_line_addr, ic_set_index, inst_valid, inst, inst_pc,
    input  ic_reqack, ic_data, ic_task_comp, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  ic_req, ic_line_addr, ic_set_index, inst_valid, inst, inst_pc,
    output ic_reqack, ic_data, ic_task_comp, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: requests 64-byte lines from the Icache, buffers one line and
// streams 32-bit words to decode; redirects may hit the buffer or retarget a miss.
module ifetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic          clk,
  input  logic          reset,
  ifetch_unit_if.master bus
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_SERVE} state_t;

  state_t       state_d, state_q;
  logic [63:2]  pc_d, pc_q;
  logic [57:0]  buf_line_d, buf_line_q;
  logic [511:0] buf_data_d, buf_data_q;
  logic         buf_valid_d, buf_valid_q;
  logic         discard_d, discard_q;
  logic         ic_req_d, ic_req_q;
  logic         buf_hit;
  logic         acked;
  logic [31:0]  buf_words [16];
  logic         unused_rpc_lsbs;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_word
      assign buf_words[gi] = buf_data_q[32*gi +: 32];
    end
  endgenerate

  assign buf_hit         = buf_valid_q && (bus.redirect_pc[63:6] == buf_line_q);
  assign acked           = ic_req_q && bus.ic_reqack;
  assign unused_rpc_lsbs = ^bus.redirect_pc[1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_line_d  = buf_line_q;
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
    discard_d   = discard_q;
    if (bus.redirect) begin
      // Redirect beats every other event; any same-cycle decode handshake is dropped.
      pc_d = bus.redirect_pc[63:2];
      case (state_q)
        S_WAIT: discard_d = 1'b1;
        S_REQ: begin
          if (acked) begin
            state_d   = S_WAIT;
            discard_d = 1'b1;
          end else begin
            state_d = buf_hit ? S_SERVE : S_REQ;
          end
        end
        default: state_d = buf_hit ? S_SERVE : S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (acked) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (bus.ic_task_comp) begin
            if (discard_q) begin
              // Line belonged to a superseded pc; refetch with the new one.
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else begin
              buf_data_d  = bus.ic_data;
              buf_line_d  = pc_q[63:6];
              buf_valid_d = 1'b1;
              state_d     = S_SERVE;
            end
          end
        end
        default: begin
          if (bus.inst_ready) begin
            pc_d = pc_q + 62'd1;
            if (pc_q[5:2] == 4'hF) state_d = S_REQ;
          end
        end
      endcase
    end
    ic_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC[63:2];
      buf_line_q  <= '0;
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
      discard_q   <= 1'b0;
      ic_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_line_q  <= buf_line_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
      discard_q   <= discard_d;
      ic_req_q    <= ic_req_d;
    end
  end

  // Every output is decoded from flops only, since the Icache samples on negedge.
  assign bus.ic_req       = ic_req_q;
  assign bus.ic_line_addr = pc_q[63:6];
  assign bus.ic_set_index = pc_q[9:6];
  assign bus.inst_valid   = (state_q == S_SERVE);
  assign bus.inst         = buf_words[pc_q[5:2]];
  assign bus.inst_pc      = {pc_q, 2'b00};
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: Icache responder, a pc/memory stream model checked every
// negedge, a directed scenario with literal expectations, then randomized traffic.
module tb_ifetch_unit;
  localparam logic [63:0] RESET_PC = 64'h1000;

  logic clk = 1'b0;
  logic reset;
  ifetch_unit_if bus();

  ifetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_hs   = 0;

  // Memory image: the word at byte address a is 0xA000_0000 + (a - 0x1000)/4.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hA000_0000 + 32'((a - 64'h1000) >> 2);
  endfunction

  function automatic logic [511:0] line_data(input logic [57:0] l);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = mem_word({l, 4'(k), 2'b00});
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Icache responder: acks after ack_lat request cycles, returns the line comp_lat
  // cycles later and keeps task_comp high until the next ack.
  int          ack_lat = 2;
  int          comp_lat = 5;
  int          req_cnt = 0;
  int          comp_cnt = 0;
  logic        icm_busy = 1'b0;
  logic        icm_rst;
  logic [57:0] pend_line;

  always @(posedge clk) begin
    icm_rst = reset;
    #2;
    bus.ic_reqack = 1'b0;
    if (icm_rst) begin
      icm_busy         = 1'b0;
      req_cnt          = 0;
      bus.ic_task_comp = 1'b1;
      bus.ic_data      = {16{32'hDEAD_BEEF}};
    end else if (icm_busy) begin
      if (comp_cnt <= 1) begin
        bus.ic_task_comp = 1'b1;
        bus.ic_data      = line_data(pend_line);
        icm_busy         = 1'b0;
        $display("icache: line %h returned", pend_line);
      end else begin
        comp_cnt--;
      end
    end else if (bus.ic_req) begin
      req_cnt++;
      if (req_cnt >= ack_lat) begin
        bus.ic_reqack    = 1'b1;
        bus.ic_task_comp = 1'b0;
        icm_busy         = 1'b1;
        comp_cnt         = comp_lat;
        pend_line        = bus.ic_line_addr;
        req_cnt          = 0;
      end
    end else begin
      req_cnt = 0;
    end
  end

  // Stream model: the next word decode must see is exp_pc, with contents mem_word(exp_pc).
  logic [63:0] exp_pc = RESET_PC;
  logic        ack_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.inst_valid) begin
      chk("inst_pc", bus.inst_pc, exp_pc);
      chk("inst", {32'h0, bus.inst}, {32'h0, mem_word(exp_pc)});
    end
    if (bus.ic_req) begin
      chk("ic_line_addr", {6'h0, bus.ic_line_addr}, {6'h0, exp_pc[63:6]});
      chk("ic_set_index", {60'h0, bus.ic_set_index}, {60'h0, exp_pc[9:6]});
    end
    if (ack_prev) chk("ic_req_after_ack", {63'h0, bus.ic_req}, 64'h0);
    if (icm_busy) chk("valid_during_miss", {63'h0, bus.inst_valid}, 64'h0);
    ack_prev = bus.ic_reqack;
    if (reset) begin
      exp_pc = RESET_PC;
    end else if (bus.redirect) begin
      exp_pc = {bus.redirect_pc[63:2], 2'b00};
    end else if (bus.inst_valid && bus.inst_ready) begin
      exp_pc = exp_pc + 64'd4;
      n_hs++;
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_ack(input string name);
    for (int n = 0; n < 60 && bus.ic_reqack !== 1'b1; n++) step();
    chk({name, "_ack_wait"}, {63'h0, bus.ic_reqack}, 64'h1);
  endtask

  task automatic wait_comp(input string name);
    for (int n = 0; n < 60 && bus.ic_task_comp !== 1'b1; n++) step();
    chk({name, "_comp_wait"}, {63'h0, bus.ic_task_comp}, 64'h1);
  endtask

  task automatic wait_valid(input string name);
    for (int n = 0; n < 80 && bus.inst_valid !== 1'b1; n++) step();
    chk({name, "_valid_wait"}, {63'h0, bus.inst_valid}, 64'h1);
  endtask

  initial begin
    reset           = 1'b1;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 64'h0;
    step();
    step();
    chk("rst_ic_req", {63'h0, bus.ic_req}, 64'h0);
    chk("rst_line_addr", {6'h0, bus.ic_line_addr}, 64'h40);
    chk("rst_set_index", {60'h0, bus.ic_set_index}, 64'h0);
    chk("rst_inst_valid", {63'h0, bus.inst_valid}, 64'h0);
    chk("rst_inst", {32'h0, bus.inst}, 64'h0);
    chk("rst_inst_pc", bus.inst_pc, 64'h1000);

    // First line fetch after reset.
    reset = 1'b0;
    step();
    chk("first_req", {63'h0, bus.ic_req}, 64'h1);
    chk("first_line_addr", {6'h0, bus.ic_line_addr}, 64'h40);
    wait_ack("a");
    step();
    chk("req_drop_after_ack", {63'h0, bus.ic_req}, 64'h0);
    wait_comp("a");
    step();
    chk("first_valid", {63'h0, bus.inst_valid}, 64'h1);
    chk("first_inst", {32'h0, bus.inst}, 64'hA000_0000);
    chk("first_inst_pc", bus.inst_pc, 64'h1000);

    // Backpressure pattern 1,0,0,1.
    bus.inst_ready = 1'b1; step(); chk("bp_pc0", bus.inst_pc, 64'h1004);
    bus.inst_ready = 1'b0; step(); chk("bp_pc1", bus.inst_pc, 64'h1004);
    step();                        chk("bp_pc2", bus.inst_pc, 64'h1004);
    chk("bp_inst_held", {32'h0, bus.inst}, 64'hA000_0001);
    bus.inst_ready = 1'b1; step(); chk("bp_pc3", bus.inst_pc, 64'h1008);

    // Buffer-hit redirect alongside a handshake: 0x1008 is not consumed.
    bus.redirect = 1'b1; bus.redirect_pc = 64'h1030;
    step();
    bus.redirect = 1'b0; bus.inst_ready = 1'b0;
    chk("hit_valid", {63'h0, bus.inst_valid}, 64'h1);
    chk("hit_pc", bus.inst_pc, 64'h1030);
    chk("hit_inst", {32'h0, bus.inst}, 64'hA000_000C);
    chk("hit_no_req", {63'h0, bus.ic_req}, 64'h0);

    // Full-rate stream across the line, then the line-cross request.
    bus.redirect = 1'b1; bus.redirect_pc = 64'h1000;
    step();
    bus.redirect = 1'b0; bus.inst_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("stream_valid", {63'h0, bus.inst_valid}, 64'h1);
      chk("stream_pc", bus.inst_pc, 64'h1000 + 64'(4 * i));
      step();
    end
    chk("cross_valid", {63'h0, bus.inst_valid}, 64'h0);
    chk("cross_req", {63'h0, bus.ic_req}, 64'h1);
    chk("cross_line", {6'h0, bus.ic_line_addr}, 64'h41);

    // Redirect while the 0x1040 miss is outstanding: returned line is dropped.
    wait_ack("b");
    step();
    bus.redirect = 1'b1; bus.redirect_pc = 64'h2003;
    step();
    bus.redirect = 1'b0; bus.inst_ready = 1'b0;
    wait_comp("b");
    step();
    chk("discard_valid", {63'h0, bus.inst_valid}, 64'h0);
    chk("discard_req", {63'h0, bus.ic_req}, 64'h1);
    chk("discard_line", {6'h0, bus.ic_line_addr}, 64'h80);
    wait_valid("c");
    chk("redir_pc", bus.inst_pc, 64'h2000);
    chk("redir_inst", {32'h0, bus.inst}, 64'hA000_0400);

    // pc wrap from the top of the address space.
    bus.redirect = 1'b1; bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    chk("wrap_miss_req", {63'h0, bus.ic_req}, 64'h1);
    chk("wrap_line", {6'h0, bus.ic_line_addr}, 64'h03FF_FFFF_FFFF_FFFF);
    wait_valid("d");
    chk("wrap_top_pc", bus.inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    chk("wrap_req", {63'h0, bus.ic_req}, 64'h1);
    chk("wrap_line0", {6'h0, bus.ic_line_addr}, 64'h0);
    wait_valid("e");
    chk("wrap_pc0", bus.inst_pc, 64'h0);

    // Reset mid-miss; the stale task_comp must be ignored until the new ack.
    bus.redirect = 1'b1; bus.redirect_pc = 64'h3000;
    step();
    bus.redirect = 1'b0;
    wait_ack("f");
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_wait_req", {63'h0, bus.ic_req}, 64'h1);
    chk("rst_wait_line", {6'h0, bus.ic_line_addr}, 64'h40);
    chk("rst_wait_valid", {63'h0, bus.inst_valid}, 64'h0);
    wait_ack("g");
    chk("stale_valid", {63'h0, bus.inst_valid}, 64'h0);
    step();
    wait_comp("g");
    step();
    chk("rst_wait_pc", bus.inst_pc, 64'h1000);
    chk("rst_wait_inst", {32'h0, bus.inst}, 64'hA000_0000);

    // Randomized traffic against the stream model.
    n_hs = 0;
    for (int c = 0; c < 4000; c++) begin
      ack_lat        = $urandom_range(1, 3);
      comp_lat       = $urandom_range(1, 6);
      bus.inst_ready = ($urandom_range(0, 3) != 0);
      bus.redirect   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0)
        bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FF80 + 64'($urandom_range(0, 127));
      else
        bus.redirect_pc = 64'h1000 + 64'($urandom_range(0, 767));
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset        = 1'b0;
    bus.redirect = 1'b0;
    chk("random_progress", {63'h0, n_hs >= 300}, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage directly upstream of the Icache. Holds the 64-bit fetch PC, issues line requests to the Icache over its req/reqack/task_comp handshake, and buffers the returned 512-bit line. It then delivers one 32-bit SPARC instruction per cycle to decode with a valid/ready handshake. It also accepts branch/trap redirects from the back end, including redirects that arrive while a cache miss is outstanding.

## Interface
Parameters:
- RESET_PC, 64'h0, fetch address loaded on reset (bits [1:0] must be 0)

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- ic_req  output  1  line request to Icache
- ic_reqack  input  1  Icache accepted the request
- ic_line_addr  output  58  line address, equal to pc[63:6]
- ic_set_index  output  4  set index, equal to pc[9:6]
- ic_data  input  512  line data from the Icache; valid while ic_task_comp=1
- ic_task_comp  input  1  Icache line-return strobe
- inst_valid  output  1  inst/inst_pc valid for decode
- inst_ready  input  1  decode accepts inst this cycle
- inst  output  32  instruction word
- inst_pc  output  64  PC of inst
- redirect  input  1  back end redirects fetch
- redirect_pc  input  64  new fetch PC; bits [1:0] ignored and treated as 0

## Operation
- Registers:
  - pc[63:2]
  - buf_line[57:0], the line tag of the buffer
  - buf_data[511:0]
  - buf_valid
  - discard flag
  - state in {REQ, WAIT, SERVE}
- Word select: word k (k = pc[5:2]) = buf_data[32k+31:32k]. inst is a combinational mux off registers; inst_pc = {pc, 2'b00}.
- REQ:
  - ic_req=1; ic_line_addr and ic_set_index are held stable from pc.
  - On ic_reqack=1 → WAIT, and ic_req=0 from the next cycle.
  - ic_req must never stay high past ack, otherwise the Icache re-accepts the request.
- WAIT:
  - ic_req=0. On ic_task_comp=1 with discard=0: buf_data←ic_data, buf_line←pc[63:6], buf_valid←1 → SERVE.
  - On ic_task_comp=1 with discard=1: data dropped, discard←0 → REQ, using the already-updated pc.
  - ic_task_comp is ignored in REQ and SERVE. It remains high from the previous completion until the next ack.
- SERVE:
  - inst_valid=1. On inst_valid&inst_ready: pc←pc+1 (word units).
  - If pc[5:2] was 15, the next line is needed → REQ. Otherwise stay in SERVE.
- Redirect (priority over every other event in the same cycle):
  - The pc is always loaded from redirect_pc[63:2]. A simultaneous inst handshake is cancelled: decode treats that word as not consumed.
  - In SERVE, or in REQ before ack: if buf_valid and redirect_pc[63:6]==buf_line → SERVE (buffer reuse, no cache access). Otherwise → REQ.
  - A redirect in REQ in the same cycle as ic_reqack: treated as WAIT with discard=1.
  - In WAIT: discard←1 and stay in WAIT. The outstanding Icache request cannot be cancelled. Multiple redirects in WAIT keep only the last pc.
- pc+1 wraps from all-ones to 0 with no error.
- Reset (any state, including mid-miss):
  - state←REQ, pc←RESET_PC[63:2], buf_valid←0, discard←0.
  - The Icache shares reset, so no completion is pending afterwards.

## Timing
- Reset values:
  - ic_req=0, ic_line_addr=RESET_PC[63:6], ic_set_index=RESET_PC[9:6]
  - inst_valid=0, inst=0 (muxed from cleared buf_data), inst_pc=RESET_PC
- First cycle after reset deasserts: ic_req=1.
- ic_reqack high in cycle N → ic_req low in cycle N+1.
- ic_task_comp high in cycle M (discard=0) → inst_valid=1 in M+1 with the correct word.
- Throughput: 1 instruction/cycle within a line while inst_ready=1. Backpressure (inst_ready=0) holds inst, inst_pc and inst_valid stable.
- Line cross: handshake on word 15 in cycle t → inst_valid=0 and ic_req=1 in t+1.
- Redirect in cycle t:
  - Buffer hit: inst_valid=1 with inst_pc=redirect_pc in t+1.
  - Miss: ic_req=1 in t+1.
- All outputs are registered or a combinational function of registers only; none depends combinationally on inputs. This is required because the Icache samples on negedge.

## Test plan
- Reset with RESET_PC=0x1000; Icache model acks in 2 cycles and completes 5 cycles later with words 0..15 = 0xA000_0000+k → ic_req=1 one cycle after reset, ic_line_addr=0x40; inst_valid rises the cycle after task_comp with inst=0xA000_0000, inst_pc=0x1000.
- Stream with inst_ready=1 → 16 consecutive instructions 0x1000..0x103C on consecutive cycles; next cycle inst_valid=0, ic_req=1, ic_line_addr=0x41.
- inst_ready toggling 1,0,0,1 on the line at 0x1000 → inst_pc sequence 0x1000, 0x1004 held 2 cycles, 0x1008; no word skipped or repeated.
- Redirect to 0x2000 during WAIT of the 0x1040 miss → returned line discarded (inst_valid stays 0); new request with ic_line_addr=0x80; first inst_pc=0x2000.
- In SERVE at 0x1008, redirect to 0x1030 → no ic_req; next cycle inst_pc=0x1030. Redirect together with inst_ready=1 → 0x1008 is not counted as consumed.
- Assert reset while in WAIT, then release → ic_req=1 one cycle after release with ic_line_addr=RESET_PC[63:6]; a stale ic_task_comp=1 held from the model is ignored until after the new ic_reqack.
